// File: rtl/imm_decode_stage.sv
// Immediate decode stage: decodes the RISC-V immediate format from the opcode,
// extends the immediate to XLEN, computes pc + imm, and holds the results in
// a two-entry skid buffer. in_ready comes straight from a register, so there
// is no combinational path from out_ready back to in_ready.
// XLEN is expected to be 32 or 64.
module imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int FMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [FMT_W-1:0] out_fmt,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_target,
    output logic             out_illegal
);

    localparam logic [FMT_W-1:0] FMT_R     = FMT_W'(0);
    localparam logic [FMT_W-1:0] FMT_I     = FMT_W'(1);
    localparam logic [FMT_W-1:0] FMT_S     = FMT_W'(2);
    localparam logic [FMT_W-1:0] FMT_B     = FMT_W'(3);
    localparam logic [FMT_W-1:0] FMT_U     = FMT_W'(4);
    localparam logic [FMT_W-1:0] FMT_J     = FMT_W'(5);
    localparam logic [FMT_W-1:0] FMT_SHAMT = FMT_W'(6);
    localparam logic [FMT_W-1:0] FMT_CSR   = FMT_W'(7);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [FMT_W-1:0] fmt;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  target;
        logic             illegal;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e   state_q, state_d;
    entry_t main_q, main_d;   // oldest entry, drives the outputs
    entry_t skid_q, skid_d;   // second entry, filled only while main is stalled
    logic   in_ready_q;
    entry_t dec;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm32;
    logic [5:0]  shamt;
    logic        accept;
    logic        drain;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    // RV64 shifts use a 6-bit shift amount; RV32 ignores instr[25].
    assign shamt  = (XLEN == 64) ? in_instr[25:20] : {1'b0, in_instr[24:20]};

    // Decode the incoming word into a complete entry before it is registered.
    always_comb begin
        imm32       = '0;
        dec.fmt     = FMT_R;
        dec.illegal = 1'b0;
        unique case (opcode)
            7'b0010011: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec.fmt = FMT_SHAMT;
                    imm32   = {26'b0, shamt};
                end else begin
                    dec.fmt = FMT_I;
                    imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
                end
            end
            7'b0000011, 7'b1100111, 7'b0001111: begin
                dec.fmt = FMT_I;
                imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0100011: begin
                dec.fmt = FMT_S;
                imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec.fmt = FMT_B;
                imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt = FMT_U;
                imm32   = {in_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                dec.fmt = FMT_J;
                imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            end
            7'b0110011: begin
                dec.fmt = FMT_R;
            end
            7'b1110011: begin
                if (funct3[2]) begin
                    dec.fmt = FMT_CSR;
                    imm32   = {27'b0, in_instr[19:15]};
                end else begin
                    dec.fmt = FMT_I;
                    imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
                end
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
        // Zero-extended formats keep bit 31 clear, so one sign extension
        // from the 32-bit form is correct for every format.
        dec.imm    = XLEN'($signed(imm32));
        dec.pc     = in_pc;
        dec.target = in_pc + dec.imm;
    end

    assign accept = in_valid && in_ready_q;
    assign drain  = (state_q != EMPTY) && out_ready;

    // State and payload registers; reset clears everything that reaches the outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            // NOTE: payload is reset only because the outputs must read 0 after reset.
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    // Next occupancy and payload moves; flush wins over any handshake.
    always_comb begin
        // NOTE: hold-by-default assignments keep this block free of latches.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = dec;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    unique case ({accept, drain})
                        2'b10: begin
                            skid_d  = dec;
                            state_d = TWO;
                        end
                        2'b11: main_d  = dec;
                        2'b01: state_d = EMPTY;
                        default: ;
                    endcase
                end
                TWO: begin
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Outputs always present the oldest entry.
    always_comb begin
        out_valid   = (state_q != EMPTY);
        in_ready    = in_ready_q;
        out_imm     = main_q.imm;
        out_fmt     = main_q.fmt;
        out_pc      = main_q.pc;
        out_target  = main_q.target;
        out_illegal = main_q.illegal;
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: a table of single-instruction decode vectors
// run through an XLEN=32 and an XLEN=64 instance, plus directed sequences for
// back-pressure ordering, flush and reset.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic [31:0] out_pc;
    logic [31:0] out_target;
    logic        out_illegal;

    logic        in_ready64;
    logic        out_valid64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic [63:0] out_pc64;
    logic [63:0] out_target64;
    logic        out_illegal64;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .FMT_W(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_pc(out_pc), .out_target(out_target),
        .out_illegal(out_illegal)
    );

    imm_decode_stage #(.XLEN(64), .FMT_W(3)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_pc({32'b0, in_pc}), .flush(flush),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_fmt(out_fmt64), .out_pc(out_pc64), .out_target(out_target64),
        .out_illegal(out_illegal64)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic [31:0] target;
        logic        illegal;
        logic [63:0] imm64;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
        // instr, pc, fmt, imm, target, illegal, imm64
        vecs[0]  = '{32'hFFF00093, 32'h0000_0000, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFF_FFFFFFFF};
        vecs[1]  = '{32'hFE000EE3, 32'h0000_0100, 3'd3, 32'hFFFFFFFC, 32'h000000FC, 1'b0, 64'hFFFFFFFF_FFFFFFFC};
        vecs[2]  = '{32'h123452B7, 32'h0000_0200, 3'd4, 32'h12345000, 32'h12345200, 1'b0, 64'h00000000_12345000};
        vecs[3]  = '{32'h40F0D093, 32'h0000_0010, 3'd6, 32'h0000000F, 32'h0000001F, 1'b0, 64'h00000000_0000000F};
        vecs[4]  = '{32'h0000007F, 32'h0000_0300, 3'd0, 32'h00000000, 32'h00000300, 1'b1, 64'h00000000_00000000};
        vecs[5]  = '{32'hFE20AC23, 32'h0000_1000, 3'd2, 32'hFFFFFFF8, 32'h00000FF8, 1'b0, 64'hFFFFFFFF_FFFFFFF8};
        vecs[6]  = '{32'h001000EF, 32'h0000_0000, 3'd5, 32'h00000800, 32'h00000800, 1'b0, 64'h00000000_00000800};
        vecs[7]  = '{32'hFFFFF06F, 32'h0000_0040, 3'd5, 32'hFFFFFFFE, 32'h0000003E, 1'b0, 64'hFFFFFFFF_FFFFFFFE};
        vecs[8]  = '{32'h3002D073, 32'h0000_0000, 3'd7, 32'h00000005, 32'h00000005, 1'b0, 64'h00000000_00000005};
        vecs[9]  = '{32'h305110F3, 32'h0000_0004, 3'd1, 32'h00000305, 32'h00000309, 1'b0, 64'h00000000_00000305};
        vecs[10] = '{32'h002081B3, 32'h0000_0008, 3'd0, 32'h00000000, 32'h00000008, 1'b0, 64'h00000000_00000000};
        vecs[11] = '{32'h7FF02283, 32'h0000_0000, 3'd1, 32'h000007FF, 32'h000007FF, 1'b0, 64'h00000000_000007FF};
        vecs[12] = '{32'h02009093, 32'h0000_0000, 3'd6, 32'h00000000, 32'h00000000, 1'b0, 64'h00000000_00000020};
        vecs[13] = '{32'h800000B7, 32'h0000_0020, 3'd4, 32'h80000000, 32'h80000020, 1'b0, 64'hFFFFFFFF_80000000};
        vecs[14] = '{32'hFF0280E7, 32'h0000_0100, 3'd1, 32'hFFFFFFF0, 32'h000000F0, 1'b0, 64'hFFFFFFFF_FFFFFFF0};
        vecs[15] = '{32'h0000000F, 32'h0000_0500, 3'd1, 32'h00000000, 32'h00000500, 1'b0, 64'h00000000_00000000};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_pc     = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst out_imm", 64'(out_imm), 64'd0);
        check("rst out_fmt", 64'(out_fmt), 64'd0);
        check("rst out_pc", 64'(out_pc), 64'd0);
        check("rst out_target", 64'(out_target), 64'd0);
        check("rst out_illegal", 64'(out_illegal), 64'd0);
        check("rst64 out_valid", 64'(out_valid64), 64'd0);
        check("rst64 in_ready", 64'(in_ready64), 64'd1);
        check("rst64 out_imm", out_imm64, 64'd0);
        check("rst64 out_pc", out_pc64, 64'd0);
        rst = 1'b0;

        // Decode table: offer one word, check it one cycle later, let it drain.
        for (int i = 0; i < 16; i++) begin
            offer(vecs[i].instr, vecs[i].pc);
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("v%0d out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("v%0d out_fmt", i), 64'(out_fmt), 64'(vecs[i].fmt));
            check($sformatf("v%0d out_imm", i), 64'(out_imm), 64'(vecs[i].imm));
            check($sformatf("v%0d out_target", i), 64'(out_target), 64'(vecs[i].target));
            check($sformatf("v%0d out_pc", i), 64'(out_pc), 64'(vecs[i].pc));
            check($sformatf("v%0d out_illegal", i), 64'(out_illegal), 64'(vecs[i].illegal));
            check($sformatf("v%0d out_fmt64", i), 64'(out_fmt64), 64'(vecs[i].fmt));
            check($sformatf("v%0d out_imm64", i), out_imm64, vecs[i].imm64);
            check($sformatf("v%0d out_target64", i), out_target64,
                  {32'b0, vecs[i].pc} + vecs[i].imm64);
            check($sformatf("v%0d out_illegal64", i), 64'(out_illegal64), 64'(vecs[i].illegal));
            @(negedge clk);
            check($sformatf("v%0d drained", i), 64'(out_valid), 64'd0);
        end

        // Back-pressure: A and B fill the buffer, C waits, order A, B, C.
        out_ready = 1'b0;
        offer(32'h00100093, 32'h0000_A000);
        @(negedge clk);
        check("bp A in_ready", 64'(in_ready), 64'd1);
        check("bp A out_pc", 64'(out_pc), 64'h0000_A000);
        offer(32'h00200093, 32'h0000_B000);
        @(negedge clk);
        check("bp full in_ready", 64'(in_ready), 64'd0);
        check("bp full out_pc", 64'(out_pc), 64'h0000_A000);
        offer(32'h00300093, 32'h0000_C000);
        @(negedge clk);
        check("bp hold in_ready", 64'(in_ready), 64'd0);
        check("bp hold out_valid", 64'(out_valid), 64'd1);
        check("bp hold out_pc", 64'(out_pc), 64'h0000_A000);
        check("bp hold out_imm", 64'(out_imm), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp B out_pc", 64'(out_pc), 64'h0000_B000);
        check("bp B out_imm", 64'(out_imm), 64'd2);
        check("bp B in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp C out_pc", 64'(out_pc), 64'h0000_C000);
        check("bp C out_imm", 64'(out_imm), 64'd3);
        @(negedge clk);
        check("bp empty out_valid", 64'(out_valid), 64'd0);

        // Flush from TWO with an offer present.
        out_ready = 1'b0;
        offer(32'h00100093, 32'h0000_1100);
        @(negedge clk);
        offer(32'h00200093, 32'h0000_2200);
        @(negedge clk);
        check("fl two in_ready", 64'(in_ready), 64'd0);
        offer(32'h00400093, 32'h0000_4400);
        flush = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl two out_valid", 64'(out_valid), 64'd0);
        check("fl two in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("fl two stays empty", 64'(out_valid), 64'd0);

        // Flush from ONE: the offer that would be accepted is dropped.
        offer(32'h00500093, 32'h0000_5500);
        @(negedge clk);
        check("fl one out_valid", 64'(out_valid), 64'd1);
        offer(32'h00600093, 32'h0000_6600);
        flush = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl one out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("fl one dropped", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        offer(32'h00700093, 32'h0000_7700);
        @(negedge clk);
        in_valid = 1'b0;
        check("fl after out_pc", 64'(out_pc), 64'h0000_7700);
        @(negedge clk);
        check("fl after drained", 64'(out_valid), 64'd0);

        // Reset while ONE, with a flush also asserted.
        out_ready = 1'b0;
        offer(32'hFFF00093, 32'h0000_8800);
        @(negedge clk);
        in_valid = 1'b0;
        check("rst1 out_valid", 64'(out_valid), 64'd1);
        rst   = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        flush = 1'b0;
        check("rst1 out_valid", 64'(out_valid), 64'd0);
        check("rst1 in_ready", 64'(in_ready), 64'd1);
        check("rst1 out_imm", 64'(out_imm), 64'd0);
        check("rst1 out_pc", 64'(out_pc), 64'd0);
        check("rst1 out_target", 64'(out_target), 64'd0);
        check("rst1 out_fmt", 64'(out_fmt), 64'd0);
        check("rst1 out_illegal", 64'(out_illegal), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
